// File: rtl/mult32x32_fast_req_ctrl.sv
// Request/response front end for the 32x32 fast multiplier: operand capture,
// start pulse, busy-window timing and a registered product output.
module mult32x32_fast_req_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        mult_start,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        a_msb_is_0,
    output logic        b_msw_is_0,
    input  logic        mult_busy,
    input  logic [63:0] mult_product,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_product,
    output logic [3:0]  out_cycles,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

    state_t      state_q, state_d;
    logic        live_q, live_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  busy_cnt_q, busy_cnt_d;
    logic [63:0] prod_q, prod_d;
    logic [3:0]  cyc_q, cyc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        start_q, start_d;
    logic        valid_q, valid_d;
    logic        accept;

    // live_q keeps in_ready low until the first clock after reset release.
    assign in_ready = ((state_q == IDLE) && live_q) || ((state_q == RESULT) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        live_d     = 1'b1;
        a_d        = a_q;
        b_d        = b_q;
        busy_cnt_d = busy_cnt_q;
        prod_d     = prod_q;
        cyc_d      = cyc_q;
        cnt_d      = cnt_q;
        start_d    = 1'b0;
        valid_d    = valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                busy_cnt_d = 4'd0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (mult_busy) begin
                    if (busy_cnt_q != 4'd15)
                        busy_cnt_d = busy_cnt_q + 4'd1;
                end else begin
                    prod_d  = mult_product;
                    cyc_d   = busy_cnt_q;
                    valid_d = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 16'd1;
                    valid_d = 1'b0;
                    if (in_valid) begin
                        a_d     = in_a;
                        b_d     = in_b;
                        start_d = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            live_q     <= 1'b0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            busy_cnt_q <= 4'd0;
            prod_q     <= 64'd0;
            cyc_q      <= 4'd0;
            cnt_q      <= 16'd0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= live_d;
            a_q        <= a_d;
            b_q        <= b_d;
            busy_cnt_q <= busy_cnt_d;
            prod_q     <= prod_d;
            cyc_q      <= cyc_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            valid_q    <= valid_d;
        end
    end

    assign mult_start  = start_q;
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign a_msb_is_0  = (a_q[31:24] == 8'd0);
    assign b_msw_is_0  = (b_q[31:16] == 16'd0);
    assign out_valid   = valid_q;
    assign out_product = prod_q;
    assign out_cycles  = cyc_q;
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_mult32x32_fast_req_ctrl.sv
// Directed + random bench for mult32x32_fast_req_ctrl with a behavioural
// multiplier model driving mult_busy / mult_product.
module tb_mult32x32_fast_req_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        mult_start;
    logic [31:0] mult_a, mult_b;
    logic        a_msb_is_0, b_msw_is_0;
    logic        mult_busy;
    logic [63:0] mult_product;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_product;
    logic [3:0]  out_cycles;
    logic [15:0] op_count;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_a = 32'd0, exp_b = 32'd0;
    logic [15:0] exp_count = 16'd0;
    bit          fast_mode = 1'b0;
    int          rem = 0;

    mult32x32_fast_req_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .a_msb_is_0(a_msb_is_0), .b_msw_is_0(b_msw_is_0),
        .mult_busy(mult_busy), .mult_product(mult_product),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_cycles(out_cycles), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic int busy_len(input logic [31:0] a, input logic [31:0] b);
        bit fa, fb;
        fa = (a[31:24] == 8'd0);
        fb = (b[31:16] == 16'd0);
        if (fa && fb)  return 3;
        if (!fa && fb) return 4;
        if (fa && !fb) return 6;
        return 8;
    endfunction

    // Multiplier model: busy high for N cycles starting the cycle after START.
    always @(negedge clk) begin
        if (!reset_n) begin
            mult_busy    = 1'b0;
            mult_product = 64'd0;
            rem          = 0;
        end else if (mult_start) begin
            rem          = fast_mode ? 0 : busy_len(exp_a, exp_b);
            mult_product = 64'(exp_a) * 64'(exp_b);
            mult_busy    = (rem > 0);
        end else begin
            mult_busy = (rem > 0);
            if (rem > 0) rem = rem - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        exp_a = a; exp_b = b;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (!in_ready && g < 50) begin
            step();
            g++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
    endtask

    task automatic start_chk();
        chk("mult_start", 64'(mult_start), 64'd1);
        chk("mult_a", 64'(mult_a), 64'(exp_a));
        chk("mult_b", 64'(mult_b), 64'(exp_b));
        chk("a_msb_is_0", 64'(a_msb_is_0), 64'(exp_a[31:24] == 8'd0));
        chk("b_msw_is_0", 64'(b_msw_is_0), 64'(exp_b[31:16] == 16'd0));
    endtask

    task automatic wait_result(input logic [63:0] prod, input int ncyc);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
            if (cyc == 2) chk("start_one_cycle", 64'(mult_start), 64'd0);
        end
        chk("latency", 64'(cyc), 64'(ncyc + 3));
        chk("out_product", out_product, prod);
        chk("out_cycles", 64'(out_cycles), 64'(ncyc));
    endtask

    task automatic drain();
        logic [63:0] held;
        held = out_product;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("op_count", 64'(op_count), 64'(exp_count));
        chk("valid_clear", 64'(out_valid), 64'd0);
        chk("product_kept", out_product, held);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] prod, input int ncyc);
        send(a, b);
        start_chk();
        wait_result(prod, ncyc);
        drain();
    endtask

    task automatic reset_zero_chk(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_start"}, 64'(mult_start), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_mult_a"}, 64'(mult_a), 64'd0);
        chk({tag, "_mult_b"}, 64'(mult_b), 64'd0);
        chk({tag, "_product"}, out_product, 64'd0);
        chk({tag, "_cycles"}, 64'(out_cycles), 64'd0);
        chk({tag, "_op_count"}, 64'(op_count), 64'd0);
        chk({tag, "_flags"}, 64'({a_msb_is_0, b_msw_is_0}), 64'd3);
    endtask

    initial begin
        logic [31:0] a, b, na, nb;
        logic [63:0] held;
        int hs, cyc;
        logic [1:0] sel;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 32'd0; in_b = 32'd0;
        #12;
        reset_zero_chk("reset");
        step();
        reset_n = 1'b1;
        chk("ready_after_release", 64'(in_ready), 64'd0);
        step();
        chk("ready_idle", 64'(in_ready), 64'd1);

        op(32'h000000FF, 32'h00000002, 64'h1FE, 3);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 8);
        op(32'h12345678, 32'h0000ABCD, 64'h12345678 * 64'h0000ABCD, 4);
        op(32'h00001234, 32'h87650000, 64'h00001234 * 64'h87650000, 6);

        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            sel = 2'($urandom_range(0, 3));
            if (sel[0]) a[31:24] = 8'd0;
            if (sel[1]) b[31:16] = 16'd0;
            op(a, b, 64'(a) * 64'(b), busy_len(a, b));
        end

        // Output stall: held result, no accept, operand inputs ignored
        a = 32'hDEADBEEF; b = 32'h00C0FFEE;
        send(a, b);
        start_chk();
        wait_result(64'(a) * 64'(b), busy_len(a, b));
        held = out_product;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_a = $urandom; in_b = $urandom;
            step();
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_ready", 64'(in_ready), 64'd0);
            chk("stall_product", out_product, held);
            chk("stall_mult_a", 64'(mult_a), 64'(a));
        end
        na = 32'h00ABCDEF; nb = 32'h00001111;
        exp_a = na; exp_b = nb;
        in_a = na; in_b = nb; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("release_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        chk("release_op_count", 64'(op_count), 64'(exp_count));
        start_chk();
        wait_result(64'(na) * 64'(nb), busy_len(na, nb));
        drain();

        // Asynchronous reset in the third WAIT cycle
        send(32'hFFFFFFFF, 32'hFFFFFFFF);
        start_chk();
        step(); step(); step();
        reset_n = 1'b0;
        #1;
        reset_zero_chk("midwait");
        exp_count = 16'd0;
        step();
        reset_n = 1'b1;
        chk("midwait_ready_release", 64'(in_ready), 64'd0);
        step();
        op(32'h00000077, 32'h00000100, 64'h7700, 3);

        // op_count wrap over 65537 handshakes using zero-busy operations
        reset_n = 1'b0;
        #1;
        step();
        reset_n = 1'b1;
        step();
        fast_mode = 1'b1;
        in_a = $urandom; in_b = $urandom;
        in_valid = 1'b1; out_ready = 1'b1;
        hs = 0; cyc = 0;
        while (hs < 65537 && cyc < 250000) begin
            step();
            cyc++;
            if (out_valid) begin
                if (hs == 0)     chk("fault_cycles_zero", 64'(out_cycles), 64'd0);
                if (hs == 65535) chk("op_count_max", 64'(op_count), 64'hFFFF);
                if (hs == 65536) chk("op_count_wrap0", 64'(op_count), 64'd0);
                hs++;
                if (hs == 65537) in_valid = 1'b0;
            end
        end
        chk("wrap_handshakes", 64'(hs), 64'd65537);
        step();
        out_ready = 1'b0;
        fast_mode = 1'b0;
        chk("op_count_wrap1", 64'(op_count), 64'd1);
        chk("wrap_idle_valid", 64'(out_valid), 64'd0);
        chk("wrap_idle_ready", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mult32x32_fast_req_ctrl.md
# mult32x32_fast_req_ctrl

Request/response front end for the 32x32 fast multiplier. It sits directly upstream of the multiplier FSM/datapath pair. It accepts operand pairs over a valid/ready handshake and holds them stable for the datapath. It derives the operand-shortcut flags, issues a one-cycle start, tracks the multiplier's busy window, and returns the 64-bit product through a registered valid/ready output with per-operation cycle statistics.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept an operand pair this cycle
- in_a  in  32  multiplicand
- in_b  in  32  multiplier
- mult_start  out  1  one-cycle start pulse to the multiplier FSM
- mult_a  out  32  held operand A to the datapath
- mult_b  out  32  held operand B to the datapath
- a_msb_is_0  out  1  mult_a[31:24] == 0
- b_msw_is_0  out  1  mult_b[31:16] == 0
- mult_busy  in  1  multiplier busy indication
- mult_product  in  64  multiplier product register
- out_valid  out  1  result held in the output register
- out_ready  in  1  consumer takes the result this cycle
- out_product  out  64  registered product
- out_cycles  out  4  busy cycles counted for this result, saturating at 15
- op_count  out  16  completed output handshakes, wraps at 0xFFFF -> 0

## Operation
- FSM states: IDLE, START, WAIT, RESULT. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture in_a/in_b into mult_a/mult_b, go to START.
- START:
  - mult_start = 1 for exactly this cycle.
  - Clear the busy counter, go to WAIT.
- WAIT:
  - Each cycle with mult_busy = 1, the busy counter increments, saturating at 15.
  - First cycle with mult_busy = 0: capture mult_product into out_product and the counter into out_cycles, go to RESULT.
- RESULT:
  - out_valid = 1.
  - in_ready = out_ready, so a new request can be accepted in the same cycle the result drains.
  - out_ready without in_valid: go to IDLE.
  - out_ready with in_valid: capture the new operands, go to START.
  - Either way, increment op_count on the out_ready handshake.
- a_msb_is_0 and b_msw_is_0 are decoded from the held mult_a/mult_b registers only. They are stable from START until the next accept.
- mult_a/mult_b change only on an input handshake. in_a/in_b are ignored at all other times.
- out_product/out_cycles change only on WAIT -> RESULT. After the handshake they keep their last values, while out_valid = 0.
- Expected out_cycles values:
  - 3: both flags 1.
  - 4: a_msb_is_0 = 0, b_msw_is_0 = 1.
  - 6: a_msb_is_0 = 1, b_msw_is_0 = 0.
  - 8: both flags 0.
- No arithmetic on the product in this block; it is passed through unchanged as 64 bits.

## Timing
- Reset (asynchronous, any state, including mid-WAIT):
  - in_ready goes to 0 until the first clock after release, then 1 in IDLE.
  - All other outputs go to 0: mult_start, out_valid, mult_a, mult_b, out_product, out_cycles, op_count.
  - a_msb_is_0 = b_msw_is_0 = 1, since the held operands reset to zero.
  - The multiplier shares the same reset, so no stale busy is possible.
- Cycle numbering, with the accept at cycle 0:
  - Cycle 1: START, mult_start = 1.
  - Cycles 2 to N+1: mult_busy = 1, where N is the busy-cycle count.
  - Cycle N+2: WAIT sees mult_busy = 0.
  - Cycle N+3: out_valid = 1.
  - Accept-to-valid latency is therefore N+3: 6, 7, 9 or 11 cycles.
- mult_busy = 0 in the first WAIT cycle is a protocol fault. The block still completes with out_cycles = 0; the bench flags it.
- mult_start is never asserted outside START. A new start can only occur after out_valid has been handshaken.
- Back-to-back throughput: with out_ready held at 1, the next START is in the cycle after RESULT.

## Test plan
- Reset release, then in_a = 0x000000FF, in_b = 0x00000002 -> flags 1/1, mult_start exactly 1 cycle, out_product = 0x1FE, out_cycles = 3, out_valid 6 cycles after accept.
- in_a = 0xFFFFFFFF, in_b = 0xFFFFFFFF -> out_product = 0xFFFFFFFE00000001, out_cycles = 8, latency 11.
- in_a = 0x12345678, in_b = 0x0000ABCD (4 cycles), then in_a = 0x00001234, in_b = 0x87650000 (6 cycles) -> products match the reference model, out_cycles = 4 and 6.
- Hold out_ready = 0 for 20 cycles in RESULT -> out_product/out_valid stable, in_ready = 0, in_a changes are ignored, mult_a unchanged. Release with in_valid = 1 -> same-cycle accept, op_count +1, START next cycle.
- Assert reset_n = 0 in the 3rd WAIT cycle -> immediate zero outputs, op_count = 0. After release, a fresh request completes correctly.
- Run 65537 handshaked operations -> op_count wraps to 0x0001.
